// File: rtl/mult_pkg.sv
// Shared constants and types for the parametrised pipelined multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mult_pkg;

    // Operand width used when the top is instantiated without overrides.
    localparam int W_DEFAULT  = 4;

    // Register stages between operand acceptance and product output.
    localparam int PIPE_DEPTH = 3;

    // Extra accumulator bits above the 2W-bit product, to absorb repeated adds.
    localparam int ACC_GUARD  = 4;

    // Operand interpretation, captured per operation and carried with the data.
    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mode_t;

endpackage

// File: rtl/mult_pp_gen.sv
// Partial-product array for a W x W multiply, split into lower and upper sums.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module mult_pp_gen
    import mult_pkg::*;
#(
    parameter int W     = 4,
    parameter int SPLIT = W / 2
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  mode_t          mode,
    output logic [2*W-1:0] lower,
    output logic [2*W-1:0] upper
);

    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] pp;

    // In signed mode the multiplicand is sign-extended to the full product width,
    // so every partial product is already a correct 2W-bit two's-complement term.
    assign a_ext = (mode == MODE_SIGNED) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};

    // Shifted partial products; the multiplier MSB carries weight -2^(W-1) when
    // signed, so that row is negated. Rows below SPLIT go to lower, the rest upper.
    always_comb begin
        lower = '0;
        upper = '0;
        pp    = '0;
        for (int i = 0; i < W; i++) begin
            pp = b[i] ? (a_ext << i) : '0;
            if ((mode == MODE_SIGNED) && (i == W - 1)) begin
                pp = -pp;
            end
            if (i < SPLIT) begin
                lower = lower + pp;
            end else begin
                upper = upper + pp;
            end
        end
    end

endmodule

// File: rtl/mult_pipe_param.sv
// W x W unsigned/signed multiplier, 3 register stages, optional accumulator (MULT_PIPE_ACC_EN).
// Latency: product valid 3 clock edges after presentation (the accepting edge counts as the first).
// Backpressure: whole pipe advances only when output is empty or taken; in_ready = !out_valid | out_ready.
module mult_pipe_param
    import mult_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int SPLIT = W / 2
) (
    input  logic                     clk100MHz,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             a_in,
    input  logic [W-1:0]             b_in,
    input  logic                     signed_mode,
`ifdef MULT_PIPE_ACC_EN
    input  logic                     acc_en,
    input  logic                     acc_clr,
    output logic [2*W+ACC_GUARD-1:0] acc_out,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*W-1:0]           product,
    output logic                     busy
);

    logic           adv;
    logic           xfer;
    logic           v0, v1, v2;
    logic [W-1:0]   a0, b0;
    mode_t          m0;
    logic [2*W-1:0] lower, upper;
    logic [2*W-1:0] lower1, upper1;

    // A single advance signal moves all stages in lock-step.
    assign adv       = !v2 || out_ready;
    assign in_ready  = adv;
    assign xfer      = in_valid && adv;
    assign out_valid = v2;
    assign busy      = v0 || v1 || v2;

    mult_pp_gen #(
        .W     (W),
        .SPLIT (SPLIT)
    ) u_pp_gen (
        .a     (a0),
        .b     (b0),
        .mode  (m0),
        .lower (lower),
        .upper (upper)
    );

    // Three-stage pipe; data registers load only with valid data so a bubble
    // never disturbs the last product seen at the output.
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            v0      <= 1'b0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            a0      <= '0;
            b0      <= '0;
            m0      <= MODE_UNSIGNED;
            lower1  <= '0;
            upper1  <= '0;
            product <= '0;
        end else if (adv) begin
            v0 <= xfer;
            v1 <= v0;
            v2 <= v1;
            if (xfer) begin
                a0 <= a_in;
                b0 <= b_in;
                m0 <= mode_t'(signed_mode);
            end
            if (v0) begin
                lower1 <= lower;
                upper1 <= upper;
            end
            if (v1) begin
                product <= lower1 + upper1;
            end
        end
    end

`ifdef MULT_PIPE_ACC_EN
    localparam int AW = 2 * W + ACC_GUARD;

    mode_t          m1, m2;
    logic [AW-1:0]  prod_ext;

    // Mode travels with each result so the accumulator knows how to extend it.
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            m1 <= MODE_UNSIGNED;
            m2 <= MODE_UNSIGNED;
        end else if (adv) begin
            if (v0) m1 <= m0;
            if (v1) m2 <= m1;
        end
    end

    assign prod_ext = (m2 == MODE_SIGNED) ? {{ACC_GUARD{product[2*W-1]}}, product}
                                          : {{ACC_GUARD{1'b0}}, product};

    // Accumulate each product as it leaves; clear wins over a same-cycle add.
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            acc_out <= '0;
        end else if (acc_clr) begin
            acc_out <= '0;
        end else if (v2 && out_ready && acc_en) begin
            acc_out <= acc_out + prod_ext;
        end
    end
`endif

endmodule

// File: tb/tb_mult_pipe_param.sv
// Bench for mult_pipe_param: W=4 and W=8 instances, scoreboard against an arithmetic model.
// Latency: checks 3-edge latency, stalls, async reset; accumulator when MULT_PIPE_ACC_EN is set.
// Backpressure: out_ready is driven low mid-stream to hold the pipe.
module tb_mult_pipe_param;
    import mult_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv4, ir4, s4, ov4, or4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;
    logic        iv8, ir8, s8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
`ifdef MULT_PIPE_ACC_EN
    logic        acc_en, acc_clr;
    logic [11:0] acc_out;
    logic [19:0] acc_out8;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int n_rx   = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp8_q[$];

    mult_pipe_param #(.W(4)) dut4 (
        .clk100MHz   (clk),
        .rst         (rst),
        .in_valid    (iv4),
        .in_ready    (ir4),
        .a_in        (a4),
        .b_in        (b4),
        .signed_mode (s4),
`ifdef MULT_PIPE_ACC_EN
        .acc_en      (acc_en),
        .acc_clr     (acc_clr),
        .acc_out     (acc_out),
`endif
        .out_valid   (ov4),
        .out_ready   (or4),
        .product     (p4),
        .busy        (busy4)
    );

    mult_pipe_param #(.W(8)) dut8 (
        .clk100MHz   (clk),
        .rst         (rst),
        .in_valid    (iv8),
        .in_ready    (ir8),
        .a_in        (a8),
        .b_in        (b8),
        .signed_mode (s8),
`ifdef MULT_PIPE_ACC_EN
        .acc_en      (1'b0),
        .acc_clr     (1'b0),
        .acc_out     (acc_out8),
`endif
        .out_valid   (ov8),
        .out_ready   (or8),
        .product     (p8),
        .busy        (busy8)
    );

    // Reference: interpret operands per mode, multiply as integers, keep 2W bits.
    function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
        int av, bv, pv;
        av = s ? int'($signed(a)) : int'(a);
        bv = s ? int'($signed(b)) : int'(b);
        pv = av * bv;
        return pv[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        if (iv4 && ir4) exp_q.push_back(ref4(a4, b4, s4));
        if (ov4 && or4) begin
            n_rx++;
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb4_underflow: observed extra result %0h expected none", p4);
            end
            if (exp_q.size() > 0) check("sb4_product", 32'(p4), 32'(exp_q.pop_front()));
        end
        if (ov8 && or8) begin
            n_cmp++;
            assert (exp8_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb8_underflow: observed extra result %0h expected none", p8);
            end
            if (exp8_q.size() > 0) check("sb8_product", 32'(p8), 32'(exp8_q.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_one4(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic s, input logic [7:0] exp);
        iv4 = 1'b1; a4 = a; b4 = b; s4 = s;
        tick();
        iv4 = 1'b0;
        tick();
        tick();
        check({tag, "_valid"}, 32'(ov4), 1);
        check(tag, 32'(p4), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        iv4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; or4 = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
`ifdef MULT_PIPE_ACC_EN
        acc_en = 1'b0; acc_clr = 1'b0;
`endif
        #12;
        check("rst_out_valid", 32'(ov4), 0);
        check("rst_product", 32'(p4), 0);
        check("rst_busy", 32'(busy4), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(ir4), 1);

        // Unsigned 15*15 with latency check.
        iv4 = 1'b1; a4 = 4'd15; b4 = 4'd15; s4 = 1'b0;
        tick();
        iv4 = 1'b0;
        for (int i = 0; i < PIPE_DEPTH - 2; i++) tick();
        check("lat_early", 32'(ov4), 0);
        tick();
        check("lat_valid", 32'(ov4), 1);
        check("u15x15", 32'(p4), 'hE1);

        // Signed corner cases.
        run_one4("s_m8xm8", 4'h8, 4'h8, 1'b1, 8'h40);
        run_one4("s_m8x7",  4'h8, 4'h7, 1'b1, 8'hC8);
        run_one4("s_m1x1",  4'hF, 4'h1, 1'b1, 8'hFF);
        tick();

        // Random stream of 16 with a 5-cycle stall; inputs churn while refused.
        begin
            int sent;
            logic acc;
            sent = 0;
            n_rx = 0;
            a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
            for (int c = 0; c < 60 && (sent < 16 || exp_q.size() > 0); c++) begin
                or4 = !(c >= 6 && c < 11);
                iv4 = (sent < 16);
                #1;
                if (!or4) begin
                    check("stall_out_valid", 32'(ov4), 1);
                    check("stall_in_ready", 32'(ir4), 0);
                    if (exp_q.size() > 0) check("stall_product", 32'(p4), 32'(exp_q[0]));
                end
                acc = iv4 && ir4;
                tick();
                if (acc) sent++;
                if (acc || !or4) begin
                    a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
                end
            end
            iv4 = 1'b0;
            or4 = 1'b1;
            check("stream_count", 32'(n_rx), 16);
            check("stream_drained", 32'(exp_q.size()), 0);
        end

        // Async reset with three results in flight.
        iv4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
            tick();
        end
        iv4 = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(ov4), 0);
        check("arst_product", 32'(p4), 0);
        check("arst_busy", 32'(busy4), 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        iv4 = 1'b1; a4 = 4'd3; b4 = 4'd5; s4 = 1'b0;
        tick();
        iv4 = 1'b0;
        tick();
        check("post_rst_early", 32'(ov4), 0);
        tick();
        check("post_rst_valid", 32'(ov4), 1);
        check("post_rst_product", 32'(p4), 15);
        tick();

        // W=8, mode alternating each cycle.
        iv8 = 1'b1;
        a8 = 8'h80; b8 = 8'h80; s8 = 1'b0; exp8_q.push_back(16'h4000); tick();
        a8 = 8'h80; b8 = 8'h80; s8 = 1'b1; exp8_q.push_back(16'h4000); tick();
        a8 = 8'hFF; b8 = 8'h02; s8 = 1'b0; exp8_q.push_back(16'h01FE); tick();
        a8 = 8'hFF; b8 = 8'h02; s8 = 1'b1; exp8_q.push_back(16'hFFFE); tick();
        iv8 = 1'b0;
        for (int i = 0; i < 10 && exp8_q.size() > 0; i++) tick();
        check("w8_drained", 32'(exp8_q.size()), 0);

`ifdef MULT_PIPE_ACC_EN
        acc_clr = 1'b1; tick(); acc_clr = 1'b0;
        acc_en = 1'b1;
        iv4 = 1'b1; s4 = 1'b1;
        a4 = 4'd2; b4 = 4'd5; tick();
        a4 = 4'd4; b4 = 4'd5; tick();
        a4 = 4'hF; b4 = 4'd5; tick();
        iv4 = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
        check("acc_sum", 32'(acc_out), 25);
        iv4 = 1'b1; a4 = 4'd1; b4 = 4'd1; tick();
        iv4 = 1'b0; tick(); tick();
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0; acc_en = 1'b0;
        check("acc_clr_prio", 32'(acc_out), 0);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
